// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, IF/ID register with valid/ready handoff, redirect and EBREAK halt.
// Optional IF_PERF_EN macro adds load/redirect performance counters.
module instr_fetch #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [31:0]        EBREAK_W = 32'h0010_0073
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef IF_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [15:0]       perf_redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] redirect_target;
    logic              valid_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] id_pc_q;
    logic              load;

    // Sequential next PC wraps naturally at ADDR_W bits.
    assign pc_d            = pc_q + ADDR_W'(4);
    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign load            = (state_q == ST_RUN) && fetch_en &&
                             (!valid_q || id_ready) && !redirect_valid;

    assign imem_addr = pc_q;
    assign id_valid  = valid_q;
    assign id_instr  = instr_q;
    assign id_pc     = id_pc_q;
    assign halted    = (state_q == ST_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            id_pc_q <= '0;
        end else if (redirect_valid) begin
            // Redirect flushes IF/ID regardless of id_ready; IDLE stays IDLE.
            pc_q    <= redirect_target;
            valid_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                state_q <= ST_RUN;
            end
        end else begin
            case (state_q)
                ST_IDLE: if (fetch_en) state_q <= ST_RUN;
                ST_RUN:  if (load && (imem_instr == EBREAK_W)) state_q <= ST_HALT;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
            if (load) begin
                instr_q <= imem_instr;
                id_pc_q <= pc_q;
                valid_q <= 1'b1;
                pc_q    <= pc_d;
            end else if (valid_q && id_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [15:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (load)           fetch_cnt_q    <= fetch_cnt_q + 32'd1;
            if (redirect_valid) redirect_cnt_q <= redirect_cnt_q + 16'd1;
        end
    end

    assign perf_fetch_cnt    = fetch_cnt_q;
    assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, wrap, pause, EBREAK, reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [7:0]  id_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halted;
    logic        ebreak_en;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [15:0] perf_redirect_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef IF_PERF_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: addi x0,x0,<addr> at every word, EBREAK at 0x10 when enabled.
    assign imem_instr = (ebreak_en && imem_addr == 8'h10) ? 32'h0010_0073
                                                          : {4'h0, imem_addr, 20'h00013};

    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready)
            $display("xfer pc=%h instr=%h", id_pc, id_instr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00; ebreak_en = 1'b0;
        tick(); tick();
        n_cmp++; if (id_valid !== 1'b0)     begin n_err++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        n_cmp++; if (id_instr !== 32'h0)    begin n_err++; $display("FAIL rst_instr: got %h want 0", id_instr); end
        n_cmp++; if (id_pc !== 8'h00)       begin n_err++; $display("FAIL rst_pc: got %h want 00", id_pc); end
        n_cmp++; if (halted !== 1'b0)       begin n_err++; $display("FAIL rst_halted: got %b want 0", halted); end
        n_cmp++; if (imem_addr !== 8'h00)   begin n_err++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 8'h00) begin
                n_err++; $display("FAIL idle_hold: valid=%b addr=%h want 0/00", id_valid, imem_addr);
            end
        end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_pc;
        fetch_en = 1'b1; id_ready = 1'b1;
        tick();
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL run_entry_bubble: valid=%b want 0", id_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_pc = 8'(4 * k);
            n_cmp++; if (id_valid !== 1'b1 || id_pc !== exp_pc || imem_addr !== exp_pc + 8'd4) begin
                n_err++; $display("FAIL stream_%0d: valid=%b pc=%h addr=%h want 1/%h/%h",
                                  k, id_valid, id_pc, imem_addr, exp_pc, exp_pc + 8'd4);
            end
        end
        n_cmp++; if (id_instr !== 32'h0080_0013) begin n_err++; $display("FAIL stream_instr: got %h want 00800013", id_instr); end
    endtask

    task automatic test_backpressure();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b1 || id_pc !== 8'h08 || id_instr !== 32'h0080_0013 || imem_addr !== 8'h0C) begin
                n_err++; $display("FAIL stall_%0d: valid=%b pc=%h instr=%h addr=%h want 1/08/00800013/0c",
                                  i, id_valid, id_pc, id_instr, imem_addr);
            end
        end
        id_ready = 1'b1;
        tick();
        n_cmp++; if (id_pc !== 8'h0C || id_instr !== 32'h00C0_0013 || imem_addr !== 8'h10) begin
            n_err++; $display("FAIL stall_release: pc=%h instr=%h addr=%h want 0c/00c00013/10", id_pc, id_instr, imem_addr);
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h43;
        tick();
        n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 8'h40) begin
            n_err++; $display("FAIL redirect_flush: valid=%b addr=%h want 0/40", id_valid, imem_addr);
        end
        redirect_valid = 1'b0; id_ready = 1'b1;
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 8'h40 || id_instr !== 32'h0400_0013 || imem_addr !== 8'h44) begin
            n_err++; $display("FAIL redirect_fetch: valid=%b pc=%h instr=%h addr=%h want 1/40/04000013/44",
                              id_valid, id_pc, id_instr, imem_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 8'hFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_cmp++; if (id_pc !== 8'hFC || id_instr !== 32'h0FC0_0013 || imem_addr !== 8'h00) begin
            n_err++; $display("FAIL wrap_fc: pc=%h instr=%h addr=%h want fc/0fc00013/00", id_pc, id_instr, imem_addr);
        end
        tick();
        n_cmp++; if (id_pc !== 8'h00 || imem_addr !== 8'h04) begin
            n_err++; $display("FAIL wrap_00: pc=%h addr=%h want 00/04", id_pc, imem_addr);
        end
    endtask

    task automatic test_fetch_pause();
        fetch_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 8'h04) begin
                n_err++; $display("FAIL pause_%0d: valid=%b addr=%h want 0/04", i, id_valid, imem_addr);
            end
        end
        fetch_en = 1'b1;
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 8'h04 || imem_addr !== 8'h08) begin
            n_err++; $display("FAIL pause_resume: valid=%b pc=%h addr=%h want 1/04/08", id_valid, id_pc, imem_addr);
        end
    endtask

    task automatic test_ebreak();
        ebreak_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h10;
        tick();
        // EBREAK now on imem_instr while redirect is still asserted: no load, no halt.
        tick();
        n_cmp++; if (halted !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 8'h10) begin
            n_err++; $display("FAIL redirect_vs_ebreak: halted=%b valid=%b addr=%h want 0/0/10", halted, id_valid, imem_addr);
        end
        redirect_valid = 1'b0; id_ready = 1'b0;
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 8'h10 || id_instr !== 32'h0010_0073 || halted !== 1'b1) begin
            n_err++; $display("FAIL ebreak_load: valid=%b pc=%h instr=%h halted=%b want 1/10/00100073/1",
                              id_valid, id_pc, id_instr, halted);
        end
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 8'h10) begin
            n_err++; $display("FAIL ebreak_held: valid=%b pc=%h want 1/10", id_valid, id_pc);
        end
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 8'h14 || halted !== 1'b1) begin
                n_err++; $display("FAIL halt_idle_%0d: valid=%b addr=%h halted=%b want 0/14/1", i, id_valid, imem_addr, halted);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 8'h20;
        tick();
        n_cmp++; if (halted !== 1'b0 || imem_addr !== 8'h20) begin
            n_err++; $display("FAIL halt_exit: halted=%b addr=%h want 0/20", halted, imem_addr);
        end
        redirect_valid = 1'b0;
        tick();
        n_cmp++; if (id_valid !== 1'b1 || id_pc !== 8'h20 || id_instr !== 32'h0200_0013 || imem_addr !== 8'h24) begin
            n_err++; $display("FAIL halt_resume: valid=%b pc=%h instr=%h addr=%h want 1/20/02000013/24",
                              id_valid, id_pc, id_instr, imem_addr);
        end
    endtask

    task automatic test_reset_midstream();
`ifdef IF_PERF_EN
        n_cmp++; if (perf_fetch_cnt !== 32'd10 || perf_redirect_cnt !== 16'd5) begin
            n_err++; $display("FAIL perf_counts: fetch=%0d redirect=%0d want 10/5", perf_fetch_cnt, perf_redirect_cnt);
        end
`endif
        id_ready = 1'b0; rst_n = 1'b0;
        tick();
        n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 8'h00 || halted !== 1'b0 || id_pc !== 8'h00) begin
            n_err++; $display("FAIL mid_reset: valid=%b addr=%h halted=%b pc=%h want 0/00/0/00",
                              id_valid, imem_addr, halted, id_pc);
        end
`ifdef IF_PERF_EN
        n_cmp++; if (perf_fetch_cnt !== 32'd0 || perf_redirect_cnt !== 16'd0) begin
            n_err++; $display("FAIL perf_reset: fetch=%0d redirect=%0d want 0/0", perf_fetch_cnt, perf_redirect_cnt);
        end
`endif
        rst_n = 1'b1;
        tick();
        n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 8'h00) begin
            n_err++; $display("FAIL post_reset_bubble: valid=%b addr=%h want 0/00", id_valid, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_pause();
        test_ebreak();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
